vga_sync_generator: RTL and testbench



---
 rtl/vga_sync_generator.sv | 112 +++++++++++
 tb/tb_vga_sync_generator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator.sv
// ----------------------------------------------------------------------------
// vga_sync_generator
//   Raster timing master for the VGA path. A column/row counter pair walks the
//   frame, and the sync/visible/frame-start flags are decoded from the value the
//   counters are about to take. The counts and the flags load on the same edge,
//   so every output describes the same pixel in the same cycle, and all outputs
//   come straight from flops.
//
// Ports
//   clock        : pixel clock
//   reset_n      : synchronous active-low reset (forces the idle output set)
//   enable       : advance the raster when high, hold every output when low
//   out_Hsync    : horizontal sync, active-low
//   out_Vsync    : vertical sync, active-low
//   column_count : current column, 0..TOTAL_COLS-1
//   row_count    : current row, 0..TOTAL_ROWS-1
//   video_active : current position lies in the visible area
//   frame_start  : high at position (0,0)
// ----------------------------------------------------------------------------
module vga_sync_generator #(
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_WIDTH  = 96,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_WIDTH  = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    output logic       out_Hsync,
    output logic       out_Vsync,
    output logic [9:0] column_count,
    output logic [9:0] row_count,
    output logic       video_active,
    output logic       frame_start
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);

    // Decode bounds are 11 bits wide so a sync window ending exactly at 1024
    // still compares correctly against a 10-bit count.
    localparam logic [10:0] H_ACT = 11'(ACTIVE_COLS);
    localparam logic [10:0] V_ACT = 11'(ACTIVE_ROWS);
    localparam logic [10:0] H_BEG = 11'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [10:0] H_END = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [10:0] V_BEG = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [10:0] V_END = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);

    state_t      state;
    logic [9:0]  col_nxt;
    logic [9:0]  row_nxt;
    logic [10:0] col_w;
    logic [10:0] row_w;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        va_nxt;
    logic        fs_nxt;

    // Next position. Leaving IDLE presents (0,0) without advancing, so the
    // first RUN cycle shows the origin fully decoded.
    always_comb begin
        col_nxt = 10'd0;
        row_nxt = 10'd0;
        if (state == RUN) begin
            col_nxt = column_count + 10'd1;
            row_nxt = row_count;
            if (column_count == COL_LAST) begin
                col_nxt = 10'd0;
                row_nxt = (row_count == ROW_LAST) ? 10'd0 : row_count + 10'd1;
            end
        end
    end

    // Flags are decoded from the next position and registered alongside it.
    always_comb begin
        col_w  = {1'b0, col_nxt};
        row_w  = {1'b0, row_nxt};
        hs_nxt = !((col_w >= H_BEG) && (col_w < H_END));
        vs_nxt = !((row_w >= V_BEG) && (row_w < V_END));
        va_nxt = (col_w < H_ACT) && (row_w < V_ACT);
        fs_nxt = (col_nxt == 10'd0) && (row_nxt == 10'd0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            column_count <= 10'd0;
            row_count    <= 10'd0;
            out_Hsync    <= 1'b1;
            out_Vsync    <= 1'b1;
            video_active <= 1'b0;
            frame_start  <= 1'b0;
        end else if (enable) begin
            // With enable low nothing loads, which freezes every output
            // (frame_start included) until the raster resumes.
            state        <= RUN;
            column_count <= col_nxt;
            row_count    <= row_nxt;
            out_Hsync    <= hs_nxt;
            out_Vsync    <= vs_nxt;
            video_active <= va_nxt;
            frame_start  <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_generator
//   Three instances share one clock: default timing (A), a narrow-line copy with
//   default vertical timing so whole frames stay short (B), and a tiny 10x6
//   raster (C). A reference raster model pushes the expected outputs of each
//   edge into a scoreboard queue; the entry is popped and compared once the
//   edge has happened. Scenario tasks add spot checks on fixed positions.
// ----------------------------------------------------------------------------
module tb_vga_sync_generator;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       va;
        logic       fs;
    } obs_t;

    localparam int TC [3] = '{800, 20, 10};
    localparam int TR [3] = '{525, 525, 6};
    localparam int AC [3] = '{640, 10, 6};
    localparam int AR [3] = '{480, 480, 4};
    localparam int HFP[3] = '{16, 2, 1};
    localparam int HSW[3] = '{96, 6, 2};
    localparam int VFP[3] = '{10, 10, 1};
    localparam int VSW[3] = '{2, 2, 1};

    localparam obs_t IDLE_O = '{col: 10'd0, row: 10'd0, hs: 1'b1, vs: 1'b1, va: 1'b0, fs: 1'b0};

    logic clock = 1'b0;
    logic rstn [3];
    logic en   [3];
    obs_t oq   [3];

    logic [9:0] col_a, row_a, col_b, row_b, col_c, row_c;
    logic hs_a, vs_a, va_a, fs_a, hs_b, vs_b, va_b, fs_b, hs_c, vs_c, va_c, fs_c;

    int   errors = 0;
    int   checks = 0;
    obs_t sb [$];
    obs_t obs;
    obs_t e;

    // reference model state per instance
    int   mc  [3];
    int   mr  [3];
    bit   mrun[3];
    obs_t mexp[3];

    always #5 clock = ~clock;

    vga_sync_generator dut_a (
        .clock(clock), .reset_n(rstn[0]), .enable(en[0]),
        .out_Hsync(hs_a), .out_Vsync(vs_a), .column_count(col_a), .row_count(row_a),
        .video_active(va_a), .frame_start(fs_a)
    );

    vga_sync_generator #(
        .TOTAL_COLS(20), .TOTAL_ROWS(525), .ACTIVE_COLS(10), .ACTIVE_ROWS(480),
        .H_FRONT_PORCH(2), .H_SYNC_WIDTH(6), .V_FRONT_PORCH(10), .V_SYNC_WIDTH(2)
    ) dut_b (
        .clock(clock), .reset_n(rstn[1]), .enable(en[1]),
        .out_Hsync(hs_b), .out_Vsync(vs_b), .column_count(col_b), .row_count(row_b),
        .video_active(va_b), .frame_start(fs_b)
    );

    vga_sync_generator #(
        .TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(6), .ACTIVE_ROWS(4),
        .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1)
    ) dut_c (
        .clock(clock), .reset_n(rstn[2]), .enable(en[2]),
        .out_Hsync(hs_c), .out_Vsync(vs_c), .column_count(col_c), .row_count(row_c),
        .video_active(va_c), .frame_start(fs_c)
    );

    assign oq[0] = '{col: col_a, row: row_a, hs: hs_a, vs: vs_a, va: va_a, fs: fs_a};
    assign oq[1] = '{col: col_b, row: row_b, hs: hs_b, vs: vs_b, va: va_b, fs: fs_b};
    assign oq[2] = '{col: col_c, row: row_c, hs: hs_c, vs: vs_c, va: va_c, fs: fs_c};

    function automatic obs_t dec(int s, int c, int r);
        obs_t o;
        o.col = 10'(c);
        o.row = 10'(r);
        o.hs  = !(c >= AC[s] + HFP[s] && c < AC[s] + HFP[s] + HSW[s]);
        o.vs  = !(r >= AR[s] + VFP[s] && r < AR[s] + VFP[s] + VSW[s]);
        o.va  = (c < AC[s]) && (r < AR[s]);
        o.fs  = (c == 0) && (r == 0);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("(%0d,%0d) hs=%b vs=%b va=%b fs=%b", o.col, o.row, o.hs, o.vs, o.va, o.fs);
    endfunction

    // Drive one edge on instance s, predict its outputs into the scoreboard,
    // then sample the DUT 1 time unit after the edge.
    task automatic step(input int s, input logic r, input logic en_v);
        rstn[s] = r;
        en[s]   = en_v;
        if (!r) begin
            mrun[s] = 1'b0; mc[s] = 0; mr[s] = 0; mexp[s] = IDLE_O;
        end else if (en_v) begin
            if (mrun[s]) begin
                if (mc[s] == TC[s] - 1) begin
                    mc[s] = 0;
                    mr[s] = (mr[s] == TR[s] - 1) ? 0 : mr[s] + 1;
                end else begin
                    mc[s] = mc[s] + 1;
                end
            end
            mrun[s] = 1'b1;
            mexp[s] = dec(s, mc[s], mr[s]);
        end
        sb.push_back(mexp[s]);
        @(posedge clock);
        #1;
        obs = oq[s];
    endtask

    task automatic test_reset(input int s);
        for (int i = 0; i < 5; i++) begin
            step(s, 1'b0, 1'b1);
            e = sb.pop_front(); checks++;
            if (obs !== e || obs !== IDLE_O) begin
                errors++; $display("FAIL reset_hold: got %s exp %s", fmt(obs), fmt(IDLE_O));
            end
        end
        step(s, 1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (obs !== e || obs.col !== 10'd0 || obs.row !== 10'd0 || obs.va !== 1'b1 || obs.fs !== 1'b1) begin
            errors++; $display("FAIL reset_release: got %s exp %s", fmt(obs), fmt(e));
        end
        step(s, 1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (obs !== e || obs.col !== 10'd1 || obs.row !== 10'd0 || obs.fs !== 1'b0) begin
            errors++; $display("FAIL reset_second: got %s exp %s", fmt(obs), fmt(e));
        end
    endtask

    task automatic test_fs_freeze();
        obs_t held;
        step(0, 1'b0, 1'b1); void'(sb.pop_front());
        step(0, 1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (obs !== e || obs.fs !== 1'b1) begin
            errors++; $display("FAIL fs_first: got %s exp %s", fmt(obs), fmt(e));
        end
        held = obs;
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (obs !== e || obs !== held || obs.fs !== 1'b1) begin
                errors++; $display("FAIL fs_hold: got %s exp %s", fmt(obs), fmt(held));
            end
        end
        step(0, 1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (obs !== e || obs.col !== 10'd1 || obs.fs !== 1'b0) begin
            errors++; $display("FAIL fs_resume: got %s exp %s", fmt(obs), fmt(e));
        end
    endtask

    task automatic test_horizontal();
        obs_t prev;
        int hs_fall = -1, hs_rise = -1, va_fall = -1, wraps = 0;
        step(0, 1'b0, 1'b1); void'(sb.pop_front());
        step(0, 1'b1, 1'b1); void'(sb.pop_front());
        prev = obs;
        for (int i = 0; i < 800; i++) begin
            step(0, 1'b1, 1'b1);
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL horiz_cycle: got %s exp %s", fmt(obs), fmt(e));
            end
            if (prev.hs && !obs.hs) hs_fall = int'(obs.col);
            if (!prev.hs && obs.hs) hs_rise = int'(obs.col);
            if (prev.va && !obs.va) va_fall = int'(obs.col);
            if (prev.col == 10'd799 && obs.col == 10'd0 && prev.row == 10'd0 && obs.row == 10'd1) wraps++;
            prev = obs;
        end
        checks++;
        if (hs_fall != 656) begin errors++; $display("FAIL hsync_fall_col: got %0d exp 656", hs_fall); end
        checks++;
        if (hs_rise != 752) begin errors++; $display("FAIL hsync_rise_col: got %0d exp 752", hs_rise); end
        checks++;
        if (va_fall != 640) begin errors++; $display("FAIL va_fall_col: got %0d exp 640", va_fall); end
        checks++;
        if (wraps != 1 || obs.col !== 10'd0 || obs.row !== 10'd1) begin
            errors++; $display("FAIL line_wrap: got %s wraps=%0d exp (0,1) wraps=1", fmt(obs), wraps);
        end
    endtask

    task automatic test_enable_freeze();
        obs_t held;
        bit   hit = 0;
        step(0, 1'b0, 1'b1); void'(sb.pop_front());
        step(0, 1'b1, 1'b1); void'(sb.pop_front());
        for (int i = 0; i < 9000 && !hit; i++) begin
            step(0, 1'b1, 1'b1);
            e = sb.pop_front();
            if (obs !== e) begin
                errors++; checks++; $display("FAIL freeze_run: got %s exp %s", fmt(obs), fmt(e));
            end
            hit = (obs.col == 10'd300 && obs.row == 10'd10);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL freeze_reach: got %s exp (300,10)", fmt(obs)); end
        held = obs;
        for (int i = 0; i < 7; i++) begin
            step(0, 1'b1, 1'b0);
            e = sb.pop_front(); checks++;
            if (obs !== e || obs !== held) begin
                errors++; $display("FAIL freeze_hold: got %s exp %s", fmt(obs), fmt(held));
            end
        end
        step(0, 1'b1, 1'b1);
        e = sb.pop_front(); checks++;
        if (obs !== e || obs.col !== 10'd301 || obs.row !== 10'd10) begin
            errors++; $display("FAIL freeze_resume: got %s exp (301,10)", fmt(obs));
        end
    endtask

    task automatic test_vertical();
        obs_t prev;
        int vs_low = 0, first_low = -1, last_low = -1, bad_vs = 0;
        int fs_cnt = 0, fs_at = -1, row_wrap = 0;
        step(1, 1'b0, 1'b1); void'(sb.pop_front());
        step(1, 1'b1, 1'b1); void'(sb.pop_front());
        prev = obs;
        for (int i = 1; i <= 10500; i++) begin
            step(1, 1'b1, 1'b1);
            e = sb.pop_front();
            if (obs !== e) begin
                errors++; checks++; $display("FAIL vert_cycle: got %s exp %s", fmt(obs), fmt(e));
            end
            if (!obs.vs) begin
                vs_low++;
                if (first_low < 0) first_low = int'(obs.row);
                last_low = int'(obs.row);
            end
            if (obs.vs !== prev.vs && obs.col != 10'd0) bad_vs++;
            if (obs.fs) begin fs_cnt++; fs_at = i; end
            if (prev.col == 10'd19 && prev.row == 10'd524 && obs.col == 10'd0 && obs.row == 10'd0) row_wrap++;
            prev = obs;
        end
        checks++;
        if (vs_low != 40) begin errors++; $display("FAIL vsync_low_cycles: got %0d exp 40", vs_low); end
        checks++;
        if (first_low != 490 || last_low != 491) begin
            errors++; $display("FAIL vsync_rows: got %0d..%0d exp 490..491", first_low, last_low);
        end
        checks++;
        if (bad_vs != 0) begin errors++; $display("FAIL vsync_mid_line: got %0d exp 0", bad_vs); end
        checks++;
        if (fs_cnt != 1 || fs_at != 10500) begin
            errors++; $display("FAIL frame_period: got cnt=%0d at=%0d exp cnt=1 at=10500", fs_cnt, fs_at);
        end
        checks++;
        if (row_wrap != 1) begin errors++; $display("FAIL row_wrap: got %0d exp 1", row_wrap); end
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        step(1, 1'b0, 1'b1); void'(sb.pop_front());
        step(1, 1'b1, 1'b1); void'(sb.pop_front());
        for (int i = 0; i < 11000 && !hit; i++) begin
            step(1, 1'b1, 1'b1);
            e = sb.pop_front();
            if (obs !== e) begin
                errors++; checks++; $display("FAIL midrst_run: got %s exp %s", fmt(obs), fmt(e));
            end
            hit = (obs.col == 10'd15 && obs.row == 10'd491);
        end
        checks++;
        if (!hit || obs.hs !== 1'b0 || obs.vs !== 1'b0) begin
            errors++; $display("FAIL midrst_pos: got %s exp (15,491) hs=0 vs=0", fmt(obs));
        end
        step(1, 1'b0, 1'b1);
        e = sb.pop_front(); checks++;
        if (obs !== e || obs !== IDLE_O) begin
            errors++; $display("FAIL midrst_idle: got %s exp %s", fmt(obs), fmt(IDLE_O));
        end
        test_reset(1);
    endtask

    task automatic test_small();
        int enabled = 0;
        bit on;
        step(2, 1'b0, 1'b1); void'(sb.pop_front());
        step(2, 1'b1, 1'b1); void'(sb.pop_front());
        for (int i = 0; i < 600 && enabled < 180; i++) begin
            on = ($urandom_range(0, 3) != 0);
            step(2, 1'b1, on);
            if (on) enabled++;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL small_cycle: got %s exp %s", fmt(obs), fmt(e));
            end
        end
        checks++;
        if (enabled != 180 || obs.col !== 10'd0 || obs.row !== 10'd0 || obs.fs !== 1'b1) begin
            errors++; $display("FAIL small_3frames: got %s en=%0d exp (0,0) fs=1 en=180", fmt(obs), enabled);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; en[i] = 1'b0;
            mc[i] = 0; mr[i] = 0; mrun[i] = 1'b0; mexp[i] = IDLE_O;
        end
        repeat (2) @(posedge clock);
        #1;
        test_reset(0);
        test_fs_freeze();
        test_horizontal();
        test_enable_freeze();
        test_vertical();
        test_mid_reset();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
